// File: rtl/ssd_pkg.sv
// ssd_pkg: shared 7-segment pattern constants (gfedcba, active-high) and scan-decoder FSM states
package ssd_pkg;
    localparam int BCD_W = 4;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    typedef enum logic [1:0] {IDLE, TRACK, CAPTURE, HOLD} state_t;
endpackage

// File: rtl/ssd_scan_decoder_ssd2dec.sv
// ssd2dec: combinational segment-to-BCD decoder
//   seg   in  7  segment pattern gfedcba
//   legal out 1  pattern is one of the ten digits
//   blank out 1  pattern is all-off
//   bcd   out 4  decoded digit (0 when not legal)
module ssd2dec
    import ssd_pkg::*;
(
    input  logic [6:0]       seg,
    output logic             legal,
    output logic             blank,
    output logic [BCD_W-1:0] bcd
);
    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        bcd   = '0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: readback monitor rebuilding per-digit BCD from a multiplexed 7-segment bus
//   clk, rst_n (sync, active-low)
//   seg_in      in  7      segment lines gfedcba, active-high
//   an_in       in  N      anode strobes, active-low, one-hot-low when driving a digit
//   dp_in/dp_out           decimal point in / captured per digit (only with SSD_DP_EN defined)
//   digits_out  out 4N     captured BCD, digit i at [4i+3:4i]
//   digit_valid out N      digit holds a legal captured value
//   frame_done  out 1      pulse: every digit captured since the previous pulse
//   pattern_err out 1      pulse: a stable illegal non-blank pattern was captured
//   err_digit   out 3      digit index of the last pattern_err
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
`ifdef SSD_DP_EN
    input  logic                    dp_in,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    pattern_err,
    output logic [2:0]              err_digit
);
    localparam logic [7:0] ST = 8'(STABLE_CYCLES);
`ifdef SSD_DP_EN
    localparam int SW = NUM_DIGITS + 8;
`else
    localparam int SW = NUM_DIGITS + 7;
`endif
    logic [SW-1:0]           smp_q, smp_d, prv_q, prv_d;
    state_t                  state_q, state_d, go_state;
    logic [7:0]              cnt_q, cnt_d, go_cnt;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d, mask_q, mask_d, an_cur, an_cap;
    logic                    frame_q, frame_d, perr_q, perr_d;
    logic [2:0]              errd_q, errd_d, idx;
    logic [3:0]              nz, bcd;
    logic                    onehot, changed, cap, legal, blank;
`ifdef SSD_DP_EN
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    assign smp_d  = {dp_in, an_in, seg_in};
    assign dp_out = dp_q;
`else
    assign smp_d  = {an_in, seg_in};
`endif
    // prv_q is the previous sample; once stable it is the value being captured
    assign prv_d  = smp_q;
    assign an_cur = smp_q[7 +: NUM_DIGITS];
    assign an_cap = prv_q[7 +: NUM_DIGITS];
    assign changed = smp_q != prv_q;

    ssd2dec u_dec (.seg(prv_q[6:0]), .legal(legal), .blank(blank), .bcd(bcd));

    always_comb begin
        nz  = '0;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nz = nz + {3'b0, ~an_cur[i]};
            if (!an_cap[i]) idx = 3'(i);
        end
        onehot = nz == 4'd1;
    end

    // Entry into tracking on a new sample: first sample counts as 1
    assign go_cnt   = onehot ? 8'd1 : 8'd0;
    assign go_state = !onehot ? IDLE : (ST <= 8'd1 ? CAPTURE : TRACK);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = go_state;
                cnt_d   = go_cnt;
            end
            TRACK: begin
                if (changed) begin
                    state_d = go_state;
                    cnt_d   = go_cnt;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = cnt_d >= ST ? CAPTURE : TRACK;
                end
            end
            CAPTURE: begin
                // a change arriving during the capture cycle starts a new track at once
                cap     = 1'b1;
                state_d = changed ? go_state : HOLD;
                cnt_d   = changed ? go_cnt : 8'd0;
            end
            HOLD: begin
                state_d = changed ? go_state : HOLD;
                cnt_d   = changed ? go_cnt : 8'd0;
            end
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        mask_d   = mask_q;
`ifdef SSD_DP_EN
        dp_d     = dp_q;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap && !an_cap[i]) begin
                if (legal) digits_d[4*i +: 4] = bcd;
                valid_d[i] = legal;
                mask_d[i]  = 1'b1;
`ifdef SSD_DP_EN
                dp_d[i]    = prv_q[SW-1];
`endif
            end
        end
        frame_d = cap && (&mask_d);
        if (frame_d) mask_d = '0;
        perr_d = cap && !legal && !blank;
        errd_d = perr_d ? idx : errd_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp_q    <= '0;
            prv_q    <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            mask_q   <= '0;
            frame_q  <= 1'b0;
            perr_q   <= 1'b0;
            errd_q   <= '0;
`ifdef SSD_DP_EN
            dp_q     <= '0;
`endif
        end else begin
            smp_q    <= smp_d;
            prv_q    <= prv_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            mask_q   <= mask_d;
            frame_q  <= frame_d;
            perr_q   <= perr_d;
            errd_q   <= errd_d;
`ifdef SSD_DP_EN
            dp_q     <= dp_d;
`endif
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_q;
    assign pattern_err = perr_q;
    assign err_digit   = errd_q;
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: randomized scoreboard bench for the 7-segment scan decoder
module tb_ssd_scan_decoder;
    localparam int N  = 4;
    localparam int ST = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     seg_in = '0;
    logic [N-1:0]   an_in = '1;
    logic [4*N-1:0] digits_out;
    logic [N-1:0]   digit_valid;
    logic           frame_done, pattern_err;
    logic [2:0]     err_digit;
`ifdef SSD_DP_EN
    logic           dp_in = 1'b0;
    logic [N-1:0]   dp_out;
`endif

    always #5 clk = ~clk;

    ssd_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(ST)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_in(seg_in),
        .an_in(an_in),
`ifdef SSD_DP_EN
        .dp_in(dp_in),
        .dp_out(dp_out),
`endif
        .digits_out(digits_out),
        .digit_valid(digit_valid),
        .frame_done(frame_done),
        .pattern_err(pattern_err),
        .err_digit(err_digit)
    );

    typedef struct {
        int             due;
        logic [4*N-1:0] dg;
        logic [N-1:0]   vl;
        logic           fr;
        logic           pe;
        logic [2:0]     ed;
        logic [N-1:0]   dp;
    } snap_t;

    snap_t        sbq[$];
    snap_t        cur, mdl;
    logic [N-1:0] mmask;
    logic [6:0]   pat[10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    logic [N-1:0] last_a = '1;
    logic [6:0]   last_s = '0;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // 0..9 for a digit, 10 for blank, -1 for anything else
    function automatic int seg_value(input logic [6:0] s);
        if (s == 7'b0) return 10;
        for (int v = 0; v < 10; v++) if (pat[v] == s) return v;
        return -1;
    endfunction

    function automatic bit is_onehot(input logic [N-1:0] a);
        return $countones(~a) == 1;
    endfunction

    function automatic int low_index(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (!a[i]) return i;
        return 0;
    endfunction

    task automatic clear_model();
        sbq.delete();
        cur   = '{default: '0};
        mdl   = '{default: '0};
        mmask = '0;
    endtask

    // Drive one constant bus value for len cycles; a one-hot value held for at least
    // ST samples yields exactly one capture, visible ST+2 edges after it is first driven.
    task automatic run(input logic [N-1:0] a, input logic [6:0] s, input logic d, input int len);
        int    i, v;
        snap_t e;
        an_in  = a;
        seg_in = s;
`ifdef SSD_DP_EN
        dp_in  = d;
`endif
        last_a = a;
        last_s = s;
        if (len >= ST && is_onehot(a)) begin
            i = low_index(a);
            v = seg_value(s);
            e = mdl;
            e.fr = 1'b0;
            e.pe = 1'b0;
            if (v >= 0 && v <= 9) begin
                e.dg[4*i +: 4] = 4'(v);
                e.vl[i] = 1'b1;
            end else e.vl[i] = 1'b0;
            if (v < 0) begin
                e.pe = 1'b1;
                e.ed = 3'(i);
            end
            e.dp[i] = d;
            mmask[i] = 1'b1;
            if (&mmask) begin
                e.fr  = 1'b1;
                mmask = '0;
            end
            e.due = cyc + ST + 2;
            mdl = e;
            sbq.push_back(e);
        end
        repeat (len) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        an_in  = '1;
        seg_in = '0;
        rst_n  = 1'b0;
        last_a = '1;
        last_s = '0;
        @(posedge clk);
        clear_model();
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compares the full output state every cycle against the scoreboard,
    // taking the next expected snapshot when its due cycle arrives.
    always @(negedge clk) begin
        if (mon_en) begin
            bit bad;
            if (sbq.size() > 0 && sbq[0].due == cyc) cur = sbq.pop_front();
            bad = digits_out !== cur.dg || digit_valid !== cur.vl || frame_done !== cur.fr ||
                  pattern_err !== cur.pe || err_digit !== cur.ed;
`ifdef SSD_DP_EN
            bad = bad || dp_out !== cur.dp;
`endif
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL outputs cyc=%0d got dg=%h vl=%b fr=%b pe=%b ed=%0d want dg=%h vl=%b fr=%b pe=%b ed=%0d",
                         cyc, digits_out, digit_valid, frame_done, pattern_err, err_digit,
                         cur.dg, cur.vl, cur.fr, cur.pe, cur.ed);
            end
            cur.fr = 1'b0;
            cur.pe = 1'b0;
        end
    end

    initial begin
        logic [N-1:0] a;
        logic [6:0]   s;
        int           r;
        clear_model();
        repeat (3) @(posedge clk);
        clear_model();
        mon_en = 1;
        #1 rst_n = 1'b1;
        run(4'b1110, pat[3], 1'b0, 10);
        for (int k = 0; k < 2; k++) begin
            run(4'b1110, pat[1], 1'b0, 8);
            run(4'b1101, pat[2], 1'b0, 8);
            run(4'b1011, pat[5], 1'b0, 8);
            run(4'b0111, pat[9], 1'b0, 8);
        end
        run(4'b1101, 7'b1110000, 1'b0, 8);
        for (int k = 0; k < 5; k++) run(4'b1011, (k % 2 == 0) ? pat[1] : pat[7], 1'b0, 3);
        run(4'b1011, pat[7], 1'b0, 6);
        run(4'b1100, pat[1], 1'b0, 8);
        run(4'b1111, pat[2], 1'b0, 8);
`ifdef SSD_DP_EN
        run(4'b0111, 7'b0000000, 1'b1, 8);
`endif
        run(4'b1101, pat[8], 1'b0, 2);
        do_reset();
        run(4'b0111, pat[4], 1'b0, 6);
        repeat (200) begin
            do begin
                r = $urandom_range(0, 4);
                a = (r == 0) ? N'($urandom) : ~(N'(1) << $urandom_range(0, N - 1));
                r = $urandom_range(0, 9);
                s = (r < 6) ? pat[$urandom_range(0, 9)] : (r < 8) ? 7'b0 : 7'($urandom);
            end while (a == last_a && s == last_s);
            run(a, s, 1'($urandom), $urandom_range(1, 9));
        end
        run('1, last_s ^ 7'b1, 1'b0, ST + 4);
        for (int t = 0; t < 20 && sbq.size() > 0; t++) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", sbq.size());
        end
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
